// File: rtl/axis_uart_bridge_pkg.sv
// Shared definitions for the AXIS-UART bridge (RX and TX halves).
//   rx_fsm              : receive byte FSM states
//   calc_clock_duration : clk cycles per UART bit period
package axis_uart_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE_ST,
        START_ST,
        DATA_ST,
        STOP_ST
    } rx_fsm;

    function automatic int unsigned calc_clock_duration(
        input int unsigned freq_hz,
        input int unsigned uart_speed
    );
        return freq_hz / uart_speed;
    endfunction

endpackage

// File: rtl/axis_uart_bridge_rx_sync.sv
// uart_rx_sync: brings the asynchronous UART line into the clk domain.
//   clk, reset : clock, asynchronous active-low reset
//   rx_async   : raw serial line (idles high)
//   rx_sync    : two-stage synchronised line
//   fall_edge  : high for one cycle when rx_sync goes 1 -> 0
// All stages reset to 1 so a released reset looks like an idle line.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx_async,
    output logic rx_sync,
    output logic fall_edge
);

    logic rx_meta;
    logic rx_sync_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_sync_d <= 1'b1;
        end else begin
            rx_meta   <= rx_async;
            rx_sync   <= rx_meta;
            rx_sync_d <= rx_sync;
        end
    end

    assign fall_edge = rx_sync_d & ~rx_sync;

endmodule

// File: rtl/axis_uart_bridge_rx.sv
// axis_uart_bridge_rx: 8N1 UART receiver packing N_BYTES bytes per AXIS word.
//   clk, reset        : clock, asynchronous active-low reset
//   UART_RX           : serial input, idles high, asynchronous to clk
//   M_AXIS_TDATA      : packed word, first received byte in [7:0]
//   M_AXIS_TVALID     : word valid (single-entry output register)
//   M_AXIS_TREADY     : consumer ready
//   FRAME_ERROR       : pulse, stop bit sampled low (partial word dropped)
//   OVERFLOW          : pulse, completed word dropped (output register busy)
//   TIMEOUT_EVENT     : pulse, partial word discarded after idle timeout
module axis_uart_bridge_rx
    import axis_uart_bridge_pkg::*;
#(
    parameter int unsigned UART_SPEED   = 115200,
    parameter int unsigned FREQ_HZ      = 100000000,
    parameter int unsigned N_BYTES      = 32,
    parameter int unsigned TIMEOUT_BITS = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 UART_RX,
    output logic [N_BYTES*8-1:0] M_AXIS_TDATA,
    output logic                 M_AXIS_TVALID,
    input  logic                 M_AXIS_TREADY,
    output logic                 FRAME_ERROR,
    output logic                 OVERFLOW,
    output logic                 TIMEOUT_EVENT
);

    localparam int unsigned CLOCK_DURATION = calc_clock_duration(FREQ_HZ, UART_SPEED);
    localparam int unsigned HALF_DURATION  = CLOCK_DURATION / 2;
    localparam int unsigned CNT_W          = (CLOCK_DURATION > 1) ? $clog2(CLOCK_DURATION) : 1;
    localparam int unsigned BC_W           = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int unsigned TIMEOUT_CLKS   = (TIMEOUT_BITS == 0) ? 1 : TIMEOUT_BITS * CLOCK_DURATION;
    localparam int unsigned IDLE_W         = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int unsigned WORD_W         = N_BYTES * 8;

    logic              rx_sync;
    logic              fall_edge;

    rx_fsm             state;
    rx_fsm             state_next;
    logic [CNT_W-1:0]  clock_counter;
    logic [2:0]        data_bit_counter;
    logic [7:0]        shift_reg;
    logic [BC_W-1:0]   byte_counter;
    logic [IDLE_W-1:0] idle_counter;
    logic [WORD_W-1:0] word_buf;
    logic [WORD_W-1:0] word_next;

    logic half_hit;
    logic bit_hit;
    logic data_sample;
    logic stop_sample;
    logic byte_ok;
    logic frame_err;
    logic last_lane;
    logic word_done;
    logic load_ok;
    logic idle_count_en;
    logic timeout_hit;

    uart_rx_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .rx_async  (UART_RX),
        .rx_sync   (rx_sync),
        .fall_edge (fall_edge)
    );

    // ---------------- byte FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE_ST;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        half_hit    = (clock_counter == CNT_W'(HALF_DURATION - 1));
        bit_hit     = (clock_counter == CNT_W'(CLOCK_DURATION - 1));
        data_sample = 1'b0;
        stop_sample = 1'b0;
        unique case (state)
            IDLE_ST: begin
                if (fall_edge) state_next = START_ST;
            end
            START_ST: begin
                // Line back high at mid start bit: treat as a glitch.
                if (half_hit) state_next = rx_sync ? IDLE_ST : DATA_ST;
            end
            DATA_ST: begin
                if (bit_hit) begin
                    data_sample = 1'b1;
                    if (data_bit_counter == 3'd7) state_next = STOP_ST;
                end
            end
            STOP_ST: begin
                if (bit_hit) begin
                    stop_sample = 1'b1;
                    state_next  = IDLE_ST;
                end
            end
        endcase
    end

    assign byte_ok       = stop_sample & rx_sync;
    assign frame_err     = stop_sample & ~rx_sync;
    assign last_lane     = (byte_counter == BC_W'(N_BYTES - 1));
    assign word_done     = byte_ok & last_lane;
    assign load_ok       = word_done & (~M_AXIS_TVALID | M_AXIS_TREADY);
    assign idle_count_en = (TIMEOUT_BITS != 0) && (state == IDLE_ST) && (byte_counter != '0);
    assign timeout_hit   = idle_count_en && (idle_counter == IDLE_W'(TIMEOUT_CLKS - 1));

    // Current word with the just-received byte merged into its lane; on the
    // last lane this is the complete word handed to the output register.
    always_comb begin
        word_next = word_buf;
        for (int unsigned i = 0; i < N_BYTES; i++) begin
            if (byte_counter == BC_W'(i)) word_next[i*8 +: 8] = shift_reg;
        end
    end

    // ---------------- bit timing, shifter, packer ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clock_counter    <= '0;
            data_bit_counter <= '0;
            shift_reg        <= '0;
            byte_counter     <= '0;
            idle_counter     <= '0;
            word_buf         <= '0;
            FRAME_ERROR      <= 1'b0;
            TIMEOUT_EVENT    <= 1'b0;
        end else begin
            if (state == IDLE_ST || (state == START_ST && half_hit) || bit_hit)
                clock_counter <= '0;
            else
                clock_counter <= clock_counter + 1'b1;

            if (data_sample) begin
                shift_reg        <= {rx_sync, shift_reg[7:1]};
                data_bit_counter <= data_bit_counter + 1'b1;
            end

            if (frame_err || timeout_hit)
                byte_counter <= '0;
            else if (byte_ok)
                byte_counter <= last_lane ? '0 : byte_counter + 1'b1;

            if (byte_ok) word_buf <= word_next;

            if (idle_count_en && !timeout_hit)
                idle_counter <= idle_counter + 1'b1;
            else
                idle_counter <= '0;

            FRAME_ERROR   <= frame_err;
            TIMEOUT_EVENT <= timeout_hit;
        end
    end

    // ---------------- single-entry output register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            M_AXIS_TDATA  <= '0;
            M_AXIS_TVALID <= 1'b0;
            OVERFLOW      <= 1'b0;
        end else begin
            if (load_ok) begin
                M_AXIS_TDATA  <= word_next;
                M_AXIS_TVALID <= 1'b1;
            end else if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                M_AXIS_TVALID <= 1'b0;
            end
            OVERFLOW <= word_done & ~load_ok;
        end
    end

endmodule

// File: doc/axis_uart_bridge_rx.md
Name: axis_uart_bridge_rx

Overview:
- UART receive half of the AXIS-UART bridge. Deserialises 8N1 frames from the UART_RX pin and packs N_BYTES consecutive bytes into one AXI-Stream word.
- Byte order mirrors the transmit side: the first received byte lands in TDATA[7:0].
- Sits between the board UART pin and any AXIS consumer, such as the transmit bridge in loopback.

Parameters:
- UART_SPEED, 115200, baud rate.
- FREQ_HZ, 100000000, clk frequency.
- N_BYTES, 32, bytes per output word; must be at least 1.
- TIMEOUT_BITS, 0, idle bit periods after which a partial word is discarded; 0 disables the timeout.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- UART_RX  in  1  serial line, idles high, asynchronous to clk.
- M_AXIS_TDATA  out  N_BYTES*8  packed word.
- M_AXIS_TVALID  out  1  word valid.
- M_AXIS_TREADY  in  1  consumer ready.
- FRAME_ERROR  out  1  one-cycle pulse: stop bit sampled low.
- OVERFLOW  out  1  one-cycle pulse: completed word dropped.
- TIMEOUT_EVENT  out  1  one-cycle pulse: partial word discarded.

Behaviour:
- Constants:
  - CLOCK_DURATION = FREQ_HZ/UART_SPEED (integer division).
  - HALF_DURATION = CLOCK_DURATION/2.
- Reset (reset=0, async assert, sync deassert usage):
  - State goes to IDLE_ST; all counters are 0.
  - Synchroniser FFs are 1.
  - M_AXIS_TVALID=0, M_AXIS_TDATA=0, all pulses 0.
- Input: 2-FF synchroniser gives rx_sync; rx_sync_d is one more register, used for edge detection.
- FSM:
  - IDLE_ST:
    - On a falling edge (rx_sync_d=1, rx_sync=0): clock_counter <= 0, go to START_ST.
    - A line held low without a preceding high never starts a frame.
  - START_ST: when clock_counter == HALF_DURATION-1:
    - rx_sync=0: counter <= 0, go to DATA_ST.
    - rx_sync=1: glitch, return to IDLE_ST; nothing is flagged.
  - DATA_ST:
    - Sample on each clock_counter == CLOCK_DURATION-1 (mid-bit), then the counter wraps to 0.
    - Shift right with the sample entering bit 7, so data is LSB-first.
    - data_bit_counter (3 bits) increments on each sample; after the 8th sample go to STOP_ST.
  - STOP_ST: sample at CLOCK_DURATION-1, then go to IDLE_ST.
    - rx_sync=1: byte accepted and written to word lane byte_counter.
    - rx_sync=0: FRAME_ERROR pulses, the byte is discarded, byte_counter <= 0 (partial word dropped).
- Packing and accepted bytes:
  - byte_counter runs 0..N_BYTES-1 and increments on each accepted byte.
  - When the accepted byte is lane N_BYTES-1, the word is complete and byte_counter <= 0.
- Output register, single entry:
  - A complete word loads TDATA and sets TVALID the cycle after the stop-bit sample cycle.
  - The load happens if TVALID=0, or if TVALID=1 and TREADY=1 in that same cycle (simultaneous handshake and load: the new word replaces the old one and TVALID stays 1).
  - Otherwise the word is dropped and OVERFLOW pulses; TDATA/TVALID are unchanged.
  - TVALID deasserts only on TVALID & TREADY with no simultaneous load.
  - TDATA is stable while TVALID=1 and TREADY=0.
- Timeout (TIMEOUT_BITS>0):
  - idle_counter counts clocks while in IDLE_ST with byte_counter != 0; it clears on leaving IDLE_ST.
  - On reaching TIMEOUT_BITS*CLOCK_DURATION-1: byte_counter <= 0, TIMEOUT_EVENT pulses.
  - The output register is unaffected.
- Latency: UART_RX falling edge to START_ST entry is 3 clk (2 synchroniser stages plus edge register).
- Reset mid-frame: the frame is abandoned, the partial word is lost, and the next falling edge starts a fresh frame.

Decomposition:
- Shared package axis_uart_bridge_pkg:
  - rx_fsm enum (IDLE_ST, START_ST, DATA_ST, STOP_ST).
  - Function calc_clock_duration(FREQ_HZ, UART_SPEED), reused by the TX side.
- Sub-module uart_rx_sync: 2-FF synchroniser with reset value 1 and edge output.
- Byte FSM, packer and output register stay in the top module.

Test Plan:
All scenarios use FREQ_HZ=1000000, UART_SPEED=100000 (CLOCK_DURATION=10), N_BYTES=4, TREADY=1 unless stated.
- Basic word: send 0x11,0x22,0x33,0x44 back to back -> one beat, TDATA=0x44332211, TVALID rises 1 clk after the 4th stop-bit sample, no flags.
- Glitch: UART_RX low for 3 clk then high -> no frame is received, FSM back in IDLE_ST, no pulses.
- Frame error: byte 0xA5 with stop bit 0, then line high, then 0x01,0x02,0x03,0x04 -> FRAME_ERROR pulses once, the next word is 0x04030201.
- Back-pressure:
  - TREADY=0, send two 4-byte words -> the first is held (TDATA=1st word), OVERFLOW pulses at the 2nd completion.
  - Then TREADY=1 -> exactly one beat with the 1st word.
- Timeout: TIMEOUT_BITS=20, send 0xAA,0xBB, then idle 250 clk, then send 0x01..0x04 -> TIMEOUT_EVENT once, output 0x04030201.
- Async reset: assert reset mid-DATA_ST of byte 2, release, send 0x55,0x66,0x77,0x88 -> TVALID=0 during reset, next beat 0x88776655.
